// File: rtl/wb_port_arb_pkg.sv
// Shared definitions for the regfile write-port arbiter.
// Holds the legacy control encodings (reset/write-enable levels, NOP address,
// zero word), the arbiter state encodings and the default starvation limit.
package wb_port_arb_pkg;

  localparam logic        RstEnable    = 1'b1;
  localparam logic        WriteEnable  = 1'b1;
  localparam logic        WriteDisable = 1'b0;

  localparam int          RegAddrBusW  = 5;
  localparam int          RegBusW      = 32;
  localparam logic [4:0]  NOPRegAddr   = 5'b00000;
  localparam logic [31:0] ZeroWord     = 32'h0000_0000;

  localparam logic        ArbIdle      = 1'b0;
  localparam logic        ArbForce     = 1'b1;

  localparam int          MaxWbWait    = 4;

endpackage

// File: rtl/wb_hold_buf.sv
// One-entry holding buffer for a long-latency result waiting for the
// regfile write port.
//   clk, rst        : clock, synchronous active-high reset
//   load            : capture load_addr/load_data, entry becomes valid
//   load_addr/data  : incoming result
//   clr             : entry leaves (drained to the regfile or squashed)
//   valid/addr/data : current entry
// load is only raised while the entry is empty and clr only while it is
// full, so the two never collide; clr still takes priority.
module wb_hold_buf
  import wb_port_arb_pkg::*;
#(
  parameter int ADDR_W = RegAddrBusW,
  parameter int DATA_W = RegBusW
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [DATA_W-1:0] load_data,
  input  logic              clr,
  output logic              valid,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] data
);

  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      valid <= 1'b0;
      addr  <= '0;
      data  <= '0;
    end else if (clr) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      addr  <= load_addr;
      data  <= load_data;
    end
  end

endmodule

// File: rtl/wb_port_arb.sv
// Arbiter for the single regfile write port.
// The in-order MEM/WB writeback normally wins; a long-latency result is
// parked in a one-entry buffer and written when the port is free. If the
// buffered result loses MAX_WAIT times, the arbiter enters FORCE for one
// cycle: stall_req freezes IF..MEM/WB and the buffer is drained, the
// pipeline write being re-presented the following cycle.
//   clk, rst                    : clock, synchronous active-high reset
//   wb_wd/wb_wreg/wb_wdata      : pipeline write request
//   lr_valid/lr_wd/lr_wdata     : long-latency result, handshake with lr_ready
//   lr_ready                    : buffer empty, can accept
//   lr_pending/lr_pend_wd       : held result for the decode interlock
//   stall_req                   : freeze request to the stall controller
//   rf_we/rf_waddr/rf_wdata     : registered regfile write port
module wb_port_arb
  import wb_port_arb_pkg::*;
#(
  parameter int ADDR_W   = RegAddrBusW,
  parameter int DATA_W   = RegBusW,
  parameter int MAX_WAIT = MaxWbWait
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] wb_wd,
  input  logic              wb_wreg,
  input  logic [DATA_W-1:0] wb_wdata,
  input  logic              lr_valid,
  input  logic [ADDR_W-1:0] lr_wd,
  input  logic [DATA_W-1:0] lr_wdata,
  output logic              lr_ready,
  output logic              lr_pending,
  output logic [ADDR_W-1:0] lr_pend_wd,
  output logic              stall_req,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata
);

  localparam logic [3:0] MaxW = 4'(MAX_WAIT);

  logic              state, state_nxt;
  logic [3:0]        wait_cnt, wait_nxt;
  logic              buf_valid;
  logic [ADDR_W-1:0] buf_addr;
  logic [DATA_W-1:0] buf_data;
  logic              pipe_req, pipe_sel, buf_sel, squash, lose, accept;

  always_comb begin
    pipe_req = wb_wreg && (wb_wd != '0);
    pipe_sel = pipe_req && (state == ArbIdle);
    buf_sel  = buf_valid && ((state == ArbForce) || !pipe_req);
    // Younger pipeline write to the same register makes the held value dead.
    squash   = pipe_sel && buf_valid && (wb_wd == buf_addr);
    lose     = buf_valid && !buf_sel && !squash;
    accept   = lr_valid && !buf_valid && (lr_wd != '0);

    wait_nxt = '0;
    if (lose) wait_nxt = (wait_cnt == MaxW) ? wait_cnt : wait_cnt + 4'd1;

    // Looking at the updated count lets the drain follow the MAX_WAIT-th
    // loss directly, without granting the pipeline one more cycle.
    state_nxt = ArbIdle;
    if (state == ArbIdle && lose && wait_nxt == MaxW) state_nxt = ArbForce;
  end

  wb_hold_buf #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_hold (
    .clk       (clk),
    .rst       (rst),
    .load      (accept),
    .load_addr (lr_wd),
    .load_data (lr_wdata),
    .clr       (buf_sel || squash),
    .valid     (buf_valid),
    .addr      (buf_addr),
    .data      (buf_data)
  );

  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      state    <= ArbIdle;
      wait_cnt <= '0;
      rf_we    <= WriteDisable;
      rf_waddr <= '0;
      rf_wdata <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_nxt;
      rf_we    <= (buf_sel || pipe_sel) ? WriteEnable : WriteDisable;
      if (buf_sel) begin
        rf_waddr <= buf_addr;
        rf_wdata <= buf_data;
      end else if (pipe_sel) begin
        rf_waddr <= wb_wd;
        rf_wdata <= wb_wdata;
      end
    end
  end

  assign lr_ready   = !buf_valid;
  assign lr_pending = buf_valid;
  assign lr_pend_wd = buf_valid ? buf_addr : '0;
  assign stall_req  = (state == ArbForce);

endmodule

// File: tb/tb_wb_port_arb.sv
module tb_wb_port_arb;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  wb_wd;
  logic        wb_wreg;
  logic [31:0] wb_wdata;
  logic        lr_valid;
  logic [4:0]  lr_wd;
  logic [31:0] lr_wdata;
  logic        lr_ready, lr_pending, stall_req, rf_we;
  logic [4:0]  lr_pend_wd, rf_waddr;
  logic [31:0] rf_wdata;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  wb_port_arb #(.ADDR_W(5), .DATA_W(32), .MAX_WAIT(4)) dut (
    .clk(clk), .rst(rst),
    .wb_wd(wb_wd), .wb_wreg(wb_wreg), .wb_wdata(wb_wdata),
    .lr_valid(lr_valid), .lr_wd(lr_wd), .lr_wdata(lr_wdata),
    .lr_ready(lr_ready), .lr_pending(lr_pending), .lr_pend_wd(lr_pend_wd),
    .stall_req(stall_req),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata)
  );

  typedef struct {
    logic        r;
    logic        wr;
    logic [4:0]  wd;
    logic [31:0] wdat;
    logic        lv;
    logic [4:0]  lwd;
    logic [31:0] ldat;
    logic        e_we;
    logic [4:0]  e_wa;
    logic [31:0] e_wdat;
    logic        e_pend;
    logic [4:0]  e_pwd;
    logic        e_stall;
    logic        e_rdy;
  } vec_t;

  vec_t vt[18];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic wr, input logic [4:0] wd, input logic [31:0] wdat,
                       input logic lv, input logic [4:0] lwd, input logic [31:0] ldat);
    rst = r; wb_wreg = wr; wb_wd = wd; wb_wdata = wdat;
    lr_valid = lv; lr_wd = lwd; lr_wdata = ldat;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_outs(input string tag, input logic we, input logic [4:0] wa, input logic [31:0] wdat,
                          input logic pend, input logic [4:0] pwd, input logic stall, input logic rdy);
    chk({tag, ".rf_we"},      32'(rf_we),      32'(we));
    chk({tag, ".rf_waddr"},   32'(rf_waddr),   32'(wa));
    chk({tag, ".rf_wdata"},   rf_wdata,        wdat);
    chk({tag, ".lr_pending"}, 32'(lr_pending), 32'(pend));
    chk({tag, ".lr_pend_wd"}, 32'(lr_pend_wd), 32'(pwd));
    chk({tag, ".stall_req"},  32'(stall_req),  32'(stall));
    chk({tag, ".lr_ready"},   32'(lr_ready),   32'(rdy));
  endtask

  // Buffer one result, then let the pipeline beat it four times (r3..r6).
  // Leaves the arbiter in FORCE with the buffered entry still held.
  task automatic starve(input string tag, input logic [4:0] baddr, input logic [31:0] bdat,
                        input logic [4:0] last_wa, input logic [31:0] last_wd);
    drive(0, 0, 0, 0, 1, baddr, bdat); tick;
    chk_outs({tag, ".load"}, 0, last_wa, last_wd, 1, baddr, 0, 0);
    for (int i = 0; i < 4; i++) begin
      drive(0, 1, 5'(3 + i), 32'h300 + 32'(i), 0, 0, 0); tick;
      chk_outs($sformatf("%s.loss%0d", tag, i + 1), 1, 5'(3 + i), 32'h300 + 32'(i),
               1, baddr, (i == 3), 0);
    end
  endtask

  initial begin
    // inputs -> outputs expected after the next edge
    //        r wr wd  wdat          lv lwd ldat          we wa  wdat          pd pwd st rdy
    vt[0]  = '{1, 0, 0, 32'h0,        1, 5, 32'hAAAA,      0, 0,  32'h0,        0, 0, 0, 1};
    vt[1]  = '{1, 0, 0, 32'h0,        1, 5, 32'hAAAA,      0, 0,  32'h0,        0, 0, 0, 1};
    vt[2]  = '{0, 0, 0, 32'h0,        1, 5, 32'hDEADBEEF,  0, 0,  32'h0,        1, 5, 0, 0};
    vt[3]  = '{0, 0, 0, 32'h0,        0, 0, 32'h0,         1, 5,  32'hDEADBEEF, 0, 0, 0, 1};
    vt[4]  = '{0, 0, 0, 32'h0,        0, 0, 32'h0,         0, 5,  32'hDEADBEEF, 0, 0, 0, 1};
    vt[5]  = '{0, 0, 0, 32'h0,        1, 9, 32'h11,        0, 5,  32'hDEADBEEF, 1, 9, 0, 0};
    vt[6]  = '{0, 1, 9, 32'h22,       0, 0, 32'h0,         1, 9,  32'h22,       0, 0, 0, 1};
    vt[7]  = '{0, 0, 0, 32'h0,        0, 0, 32'h0,         0, 9,  32'h22,       0, 0, 0, 1};
    vt[8]  = '{0, 0, 0, 32'h0,        0, 0, 32'h0,         0, 9,  32'h22,       0, 0, 0, 1};
    vt[9]  = '{0, 0, 0, 32'h0,        1, 2, 32'h22220002,  0, 9,  32'h22,       1, 2, 0, 0};
    vt[10] = '{0, 1, 0, 32'h0BAD,     0, 0, 32'h0,         1, 2,  32'h22220002, 0, 0, 0, 1};
    vt[11] = '{0, 1, 0, 32'h0BAD,     0, 0, 32'h0,         0, 2,  32'h22220002, 0, 0, 0, 1};
    vt[12] = '{0, 0, 0, 32'h0,        1, 0, 32'h55,        0, 2,  32'h22220002, 0, 0, 0, 1};
    vt[13] = '{0, 0, 0, 32'h0,        0, 0, 32'h0,         0, 2,  32'h22220002, 0, 0, 0, 1};
    vt[14] = '{0, 1, 17, 32'h1234,    0, 0, 32'h0,         1, 17, 32'h1234,     0, 0, 0, 1};
    vt[15] = '{0, 1, 3, 32'h33,       1, 4, 32'h44,        1, 3,  32'h33,       1, 4, 0, 0};
    vt[16] = '{0, 0, 0, 32'h0,        1, 6, 32'h66,        1, 4,  32'h44,       0, 0, 0, 1};
    vt[17] = '{0, 0, 0, 32'h0,        0, 0, 32'h0,         0, 4,  32'h44,       0, 0, 0, 1};

    drive(1, 0, 0, 0, 0, 0, 0);
    #2;
    foreach (vt[i]) begin
      drive(vt[i].r, vt[i].wr, vt[i].wd, vt[i].wdat, vt[i].lv, vt[i].lwd, vt[i].ldat);
      tick;
      chk_outs($sformatf("vec%0d", i), vt[i].e_we, vt[i].e_wa, vt[i].e_wdat,
               vt[i].e_pend, vt[i].e_pwd, vt[i].e_stall, vt[i].e_rdy);
    end

    // Starvation: r7 loses four times, one stall cycle drains r7, then the
    // held pipeline write r10 lands.
    starve("starve", 7, 32'h77, 4, 32'h44);
    drive(0, 1, 10, 32'h1010, 0, 0, 0); tick;
    chk_outs("starve.drain", 1, 7, 32'h77, 0, 0, 0, 1);
    tick;
    chk_outs("starve.held", 1, 10, 32'h1010, 0, 0, 0, 1);
    drive(0, 0, 0, 0, 0, 0, 0); tick;
    chk_outs("starve.quiet", 0, 10, 32'h1010, 0, 0, 0, 1);

    // Reset while in FORCE with r8 held: entry discarded, never written.
    starve("rstforce", 8, 32'h88, 10, 32'h1010);
    drive(1, 1, 10, 32'h1010, 0, 0, 0); tick;
    chk_outs("rstforce.rst", 0, 0, 32'h0, 0, 0, 0, 1);
    drive(0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 6; i++) begin
      tick;
      chk_outs($sformatf("rstforce.after%0d", i), 0, 0, 32'h0, 0, 0, 0, 1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
